// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: state encodings and default sizing for the fetch/execute sequencer.
package pc_seq_pkg;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_ADDR = 3'd1,
        FETCH_DATA = 3'd2,
        EXEC       = 3'd3,
        HALTED     = 3'd4
    } state_t;
    localparam int STEP_W_DEF    = 3;
    localparam int MAX_STEPS_DEF = 8;
    localparam int CNT_W_DEF     = 16;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: memory/microcode handshake and PC/IR control strobes of the sequencer.
// step_req exists only when PC_SEQ_SINGLE_STEP_EN is defined.
interface pc_sequencer_if #(
    parameter int STEP_W = 3,
    parameter int CNT_W  = 16
);
    logic              mem_ready;
    logic              jump_req;
    logic              exec_done;
    logic              halt;
`ifdef PC_SEQ_SINGLE_STEP_EN
    logic              step_req;
`endif
    logic              pc_load_bar;
    logic              pc_en_bar;
    logic              pc_inc;
    logic              ar_load;
    logic              ir_load;
    logic [STEP_W-1:0] step;
    logic [2:0]        state;
    logic [CNT_W-1:0]  instr_count;
    modport master (
        input  mem_ready, jump_req, exec_done, halt,
`ifdef PC_SEQ_SINGLE_STEP_EN
        input  step_req,
`endif
        output pc_load_bar, pc_en_bar, pc_inc, ar_load, ir_load, step, state, instr_count
    );
    modport slave (
        output mem_ready, jump_req, exec_done, halt,
`ifdef PC_SEQ_SINGLE_STEP_EN
        output step_req,
`endif
        input  pc_load_bar, pc_en_bar, pc_inc, ar_load, ir_load, step, state, instr_count
    );
endinterface

// File: rtl/pc_seq_step_ctr.sv
// pc_seq_step_ctr: microstep counter with clear, increment and terminal-count flag.
module pc_seq_step_ctr #(
    parameter int STEP_W    = 3,
    parameter int MAX_STEPS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [STEP_W-1:0] step,
    output logic              tc
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) step <= '0;
        else if (clr) step <= '0;
        else if (inc) step <= step + 1'b1;
    end
    assign tc = step == STEP_W'(MAX_STEPS - 1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute FSM driving PC, address-register and instruction-register strobes.
// Optional PC_SEQ_SINGLE_STEP_EN gates each fetch on a step_req pulse.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int STEP_W    = STEP_W_DEF,
    parameter int MAX_STEPS = MAX_STEPS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.master bus
);
    state_t            state_q, state_d;
    logic              go, fin, tc;
    logic [STEP_W-1:0] step_w;
    logic [CNT_W-1:0]  cnt_q;
`ifdef PC_SEQ_SINGLE_STEP_EN
    assign go = bus.step_req;
`else
    assign go = 1'b1;
`endif
    // an instruction retires on microcode's done or when the step budget runs out
    assign fin = state_q == EXEC && (bus.exec_done || tc);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:       state_d = bus.halt ? HALTED : FETCH_ADDR;
            FETCH_ADDR: state_d = go ? FETCH_DATA : FETCH_ADDR;
            FETCH_DATA: state_d = bus.mem_ready ? EXEC : FETCH_DATA;
            EXEC:       state_d = fin ? (bus.halt ? HALTED : FETCH_ADDR) : EXEC;
            HALTED:     state_d = bus.halt ? HALTED : FETCH_ADDR;
            default:    state_d = IDLE;
        endcase
    end
    // load and increment live in disjoint states, so they can never collide
    always_comb begin
        bus.pc_en_bar   = !(state_q == FETCH_ADDR && go);
        bus.ar_load     = state_q == FETCH_ADDR && go;
        bus.ir_load     = state_q == FETCH_DATA && bus.mem_ready;
        bus.pc_inc      = state_q == FETCH_DATA && bus.mem_ready;
        bus.pc_load_bar = !(state_q == EXEC && bus.jump_req);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else if (fin) cnt_q <= cnt_q + 1'b1;
    end
    pc_seq_step_ctr #(.STEP_W(STEP_W), .MAX_STEPS(MAX_STEPS)) u_step (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != EXEC || fin),
        .inc   (state_q == EXEC),
        .step  (step_w),
        .tc    (tc)
    );
    assign bus.step        = step_w;
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of fetch/execute sequencing, strobes, halt, reset and counter wrap.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    logic [15:0] pc_m = 16'd0;
    logic [15:0] ar_m = 16'd0;
    logic [15:0] bus_v;
    pc_sequencer_if #(.STEP_W(3), .CNT_W(16)) b ();
    pc_sequencer_if #(.STEP_W(3), .CNT_W(4))  w ();
    assign w.mem_ready = b.mem_ready;
    assign w.jump_req  = b.jump_req;
    assign w.exec_done = b.exec_done;
    assign w.halt      = b.halt;
`ifdef PC_SEQ_SINGLE_STEP_EN
    assign w.step_req  = b.step_req;
`endif
    pc_sequencer dut (.clk(clk), .reset(reset), .bus(b.master));
    pc_sequencer #(.CNT_W(4)) dut_w (.clk(clk), .reset(reset), .bus(w.master));
    always #5 clk = ~clk;
    // PC and address-register model; the data bus carries 6502 unless the PC drives it
    assign bus_v = b.pc_en_bar ? 16'd6502 : pc_m;
    always @(posedge clk) begin
        if (!b.pc_load_bar) pc_m <= bus_v;
        else if (b.pc_inc) pc_m <= pc_m + 16'd1;
        if (b.ar_load) ar_m <= bus_v;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [4:0] strb();
        return {b.pc_load_bar, b.pc_en_bar, b.pc_inc, b.ar_load, b.ir_load};
    endfunction
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic quick(input int last);
        cyc();
        cyc();
        repeat (last) cyc();
        b.exec_done = 1'b1;
        cyc();
        b.exec_done = 1'b0;
        exp_cnt++;
    endtask
    always @(negedge clk) begin
        if (!reset) begin
            chk("inv_inc_load", 32'(b.pc_inc && !b.pc_load_bar), 0);
            chk("inv_en_state", 32'(!b.pc_en_bar && b.state != 3'd1), 0);
        end
    end
    initial begin
        reset = 1'b1;
        b.mem_ready = 1'b0;
        b.jump_req = 1'b0;
        b.exec_done = 1'b0;
        b.halt = 1'b0;
`ifdef PC_SEQ_SINGLE_STEP_EN
        b.step_req = 1'b1;
`endif
        cyc();
        cyc();
        chk("rst_state", b.state, 0);
        chk("rst_strb", strb(), 5'b11000);
        chk("rst_cnt", b.instr_count, 0);
        reset = 1'b0;
        b.mem_ready = 1'b1;
        #1;
        chk("idle_state", b.state, 0);
        chk("idle_strb", strb(), 5'b11000);
        cyc();
        chk("fa_state", b.state, 1);
        chk("fa_strb", strb(), 5'b10010);
        cyc();
        chk("fd_state", b.state, 2);
        chk("fd_strb", strb(), 5'b11101);
        cyc();
        chk("ex0_state", b.state, 3);
        chk("ex0_step", b.step, 0);
        chk("ex0_strb", strb(), 5'b11000);
        cyc();
        chk("ex1_step", b.step, 1);
        cyc();
        chk("ex2_step", b.step, 2);
        b.exec_done = 1'b1;
        #1;
        chk("ex2_strb", strb(), 5'b11000);
        cyc();
        b.exec_done = 1'b0;
        exp_cnt++;
        chk("i1_state", b.state, 1);
        chk("i1_step", b.step, 0);
        chk("i1_cnt", b.instr_count, 32'(exp_cnt));
        chk("i1_cnt_w", w.instr_count, 32'(exp_cnt % 16));
        quick(2);
        chk("i2_cnt", b.instr_count, 32'(exp_cnt));
        // wait states, with exec_done asserted while it must be ignored
        b.mem_ready = 1'b0;
        b.exec_done = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("wait_state", b.state, 2);
            chk("wait_strb", strb(), 5'b11000);
            cyc();
        end
        b.exec_done = 1'b0;
        b.mem_ready = 1'b1;
        #1;
        chk("wait_end_state", b.state, 2);
        chk("wait_end_strb", strb(), 5'b11101);
        cyc();
        b.exec_done = 1'b1;
        #1;
        chk("wait_ex_state", b.state, 3);
        cyc();
        b.exec_done = 1'b0;
        exp_cnt++;
        chk("wait_fa_state", b.state, 1);
        chk("wait_cnt", b.instr_count, 32'(exp_cnt));
        // jump together with done
        b.jump_req = 1'b1;
        #1;
        chk("jmp_ignored_fa", strb(), 5'b10010);
        cyc();
        b.jump_req = 1'b0;
        cyc();
        cyc();
        chk("jmp_step", b.step, 1);
        b.jump_req = 1'b1;
        b.exec_done = 1'b1;
        #1;
        chk("jmp_strb", strb(), 5'b01000);
        cyc();
        b.jump_req = 1'b0;
        b.exec_done = 1'b0;
        exp_cnt++;
        chk("jmp_next_state", b.state, 1);
        chk("jmp_next_strb", strb(), 5'b10010);
        cyc();
        chk("jmp_ar", ar_m, 16'd6502);
        cyc();
        chk("jmp_pc_inc", pc_m, 16'd6503);
        b.exec_done = 1'b1;
        cyc();
        b.exec_done = 1'b0;
        exp_cnt++;
        // step cap without exec_done
        cyc();
        cyc();
        for (int s = 0; s < 8; s++) begin
            chk("cap_step", b.step, 32'(s));
            chk("cap_state", b.state, 3);
            cyc();
        end
        exp_cnt++;
        chk("cap_end_state", b.state, 1);
        chk("cap_end_step", b.step, 0);
        chk("cap_cnt", b.instr_count, 32'(exp_cnt));
        repeat (12) quick(0);
        chk("bulk_cnt", b.instr_count, 32'(exp_cnt));
        chk("wrap_cnt_w", w.instr_count, 32'(exp_cnt % 16));
        // halt raised mid-instruction
        cyc();
        cyc();
        b.halt = 1'b1;
        cyc();
        cyc();
        b.exec_done = 1'b1;
        cyc();
        b.exec_done = 1'b0;
        exp_cnt++;
        chk("halt_state", b.state, 4);
        chk("halt_strb", strb(), 5'b11000);
        chk("halt_cnt", b.instr_count, 32'(exp_cnt));
        cyc();
        chk("halt_hold", b.state, 4);
        b.halt = 1'b0;
        cyc();
        chk("halt_resume", b.state, 1);
`ifdef PC_SEQ_SINGLE_STEP_EN
        b.step_req = 1'b0;
        #1;
        chk("ss_hold_strb", strb(), 5'b11000);
        cyc();
        chk("ss_hold_state", b.state, 1);
        b.step_req = 1'b1;
        #1;
        chk("ss_go_strb", strb(), 5'b10010);
        cyc();
        b.step_req = 1'b0;
        chk("ss_fd_state", b.state, 2);
        cyc();
        b.exec_done = 1'b1;
        cyc();
        b.exec_done = 1'b0;
        exp_cnt++;
        cyc();
        cyc();
        chk("ss_idle_state", b.state, 1);
        chk("ss_cnt", b.instr_count, 32'(exp_cnt));
        b.step_req = 1'b1;
`endif
        // asynchronous reset in the middle of a fetch
        b.mem_ready = 1'b0;
        cyc();
        cyc();
        chk("pre_rst_state", b.state, 2);
        reset = 1'b1;
        #1;
        chk("arst_state", b.state, 0);
        chk("arst_strb", strb(), 5'b11000);
        chk("arst_cnt", b.instr_count, 0);
        chk("arst_step", b.step, 0);
        chk("arst_cnt_w", w.instr_count, 0);
        cyc();
        reset = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
